hsv2rgb_top: RTL and testbench
==============================

// Module: hsv2rgb_top
// PURPOSE
//  Pipelined HSV->RGB converter; inverse of the colour-space stage feeding the threshold logic.
//  Accepts the packed HSV24 pixel format produced upstream and returns RGB24 at pixel rate.
//  Used for on-screen overlay/debug display of HSV-domain results; sideband sync bits ride along.
// PARAMETERS
//  SYNC_W   3   width of sideband bus (de/hsync/vsync) delayed in step with the pixel
//  CNT_W    16  width of saturating out-of-range-hue counter
// PORTS
//  pclk        in   1       pixel clock; all logic on rising edge
//  rst         in   1       asynchronous, active-high reset
//  ce          in   1       pipeline clock-enable; low = every stage holds its contents
//  in_valid    in   1       HSV24 qualifies this cycle
//  HSV24       in   24      [23:16] H = degrees/2 (0..179), [15:8] S (0..255), [7:0] V (0..255)
//  in_sync     in   SYNC_W  sideband, delayed with pixel
//  out_valid   out  1       RGB24 qualifies this cycle
//  RGB24       out  24      [23:16] R, [15:8] G, [7:0] B
//  out_sync    out  SYNC_W  delayed sideband
//  hue_err_cnt out  CNT_W   count of accepted pixels with H>179; saturates at all-ones
// BEHAVIOUR
//  Reset: out_valid=0, RGB24=0, out_sync=0, hue_err_cnt=0, all stage valids cleared; async assert.
//  Latency: exactly 4 ce-enabled cycles input->output; throughput 1 pixel/cycle when ce=1.
//  ce=0: no register updates anywhere (incl. counter); outputs hold. No back-pressure otherwise.
//  Data regs update on every ce cycle regardless of valid; valid/sync are shifted alongside.
//  S1: H>179 -> H clamped to 179, hue_err_cnt++ (only if in_valid). h2=2*H (0..358),
//      sector=h2/60 (0..5), f=h2-60*sector (0..59).
//  S2: products V*(255-S), S*f, S*(60-f) (16-bit each).
//  S3: p=V*(255-S)/255; q=V*(15300-S*f)/15300; t=V*(15300-S*(60-f))/15300.
//      Numerators up to 22 bits; results 8 bits; integer floor division by constants.
//      Any reciprocal-multiply implementation must be bit-exact with the floor result.
//  S4 select (R,G,B): 0:(V,t,p) 1:(q,V,p) 2:(p,V,t) 3:(p,q,V) 4:(t,p,V) 5:(V,p,q).
//  S=0 yields R=G=B=V through the formulas; no special case required.
//  hue_err_cnt increments and saturates in the same cycle: no wrap at all-ones.
//  Reset mid-stream: all in-flight pixels discarded; first output after release appears 4 ce cycles later.
// CONFIGURATION
//  HSV2RGB_ROUND_EN defined: p,q,t use round-half-up: (num+127)/255, (num+7650)/15300.
//  Not defined: plain floor division as above. Latency, interface and select table unchanged.
// STRUCTURE
//  hsv_defs.vh: localparams HUE_MAX=179, DEG_PER_SECTOR=60, S_FULL=255, QT_DEN=15300,
//    sector encodings, HSV24/RGB24 field offsets (shared with the RGB->HSV stage).
//  Sub-module hsv2rgb_scale: registered V*(D-x)/D for a given D; three instances (p,q,t).
// TESTING
//  H=0,S=255,V=255 -> RGB24=FF0000 exactly 4 cycles later, out_valid pulses aligned.
//  H=60 -> 00FF00; H=120 -> 0000FF (S=255,V=255); S=0,V=128,any H -> 808080.
//  H=15,S=255,V=200 (30 deg) -> R=200,G=100,B=0.
//  H=200,S=255,V=255 -> clamped to 358 deg: RGB=(255,0,8); with HSV2RGB_ROUND_EN (255,0,9); cnt=1.
//  Stream 10 pixels, drop ce for 3 cycles mid-stream -> outputs/sync freeze then resume, no loss.
//  Assert rst with 3 pixels in flight -> outputs 0 immediately, none emerge after release; cnt
//    preset near all-ones plus 3 bad hues -> saturates, no wrap.

Source files
------------

// File: rtl/hsv2rgb_pkg.sv
// Shared definitions for the HSV->RGB converter: colour-space constants,
// hue-sector encodings and HSV24/RGB24 field offsets.
package hsv2rgb_pkg;

    localparam int HUE_MAX        = 179;
    localparam int DEG_PER_SECTOR = 60;
    localparam int S_FULL         = 255;
    localparam int QT_DEN         = 15300;

    localparam int H_OFS = 16;
    localparam int S_OFS = 8;
    localparam int V_OFS = 0;
    localparam int R_OFS = 16;
    localparam int G_OFS = 8;
    localparam int B_OFS = 0;

    // 60-degree hue sectors, named after the colours they span
    typedef enum logic [2:0] {
        SEC_RY = 3'd0,
        SEC_YG = 3'd1,
        SEC_GC = 3'd2,
        SEC_CB = 3'd3,
        SEC_BM = 3'd4,
        SEC_MR = 3'd5
    } sector_e;

    // Sector of a hue in degrees (0..358); compare chain instead of a divider
    function automatic sector_e sector_of(input logic [8:0] h2);
        sector_e s;
        if      (h2 < 9'(1 * DEG_PER_SECTOR)) s = SEC_RY;
        else if (h2 < 9'(2 * DEG_PER_SECTOR)) s = SEC_YG;
        else if (h2 < 9'(3 * DEG_PER_SECTOR)) s = SEC_GC;
        else if (h2 < 9'(4 * DEG_PER_SECTOR)) s = SEC_CB;
        else if (h2 < 9'(5 * DEG_PER_SECTOR)) s = SEC_BM;
        else                                  s = SEC_MR;
        return s;
    endfunction

endpackage

// File: rtl/hsv2rgb_if.sv
// Pixel stream bundle for the HSV->RGB converter: HSV24 in, RGB24 out,
// each with a qualifier and sideband sync bits. master = pixel source/sink,
// slave = converter.
interface hsv2rgb_if #(
    parameter int SYNC_W = 3
);
    logic              in_valid;
    logic [23:0]       HSV24;
    logic [SYNC_W-1:0] in_sync;
    logic              out_valid;
    logic [23:0]       RGB24;
    logic [SYNC_W-1:0] out_sync;

    modport master (
        output in_valid, HSV24, in_sync,
        input  out_valid, RGB24, out_sync
    );

    modport slave (
        input  in_valid, HSV24, in_sync,
        output out_valid, RGB24, out_sync
    );
endinterface

// File: rtl/hsv2rgb_scale.sv
// Registered V*(D-x)/D for a constant denominator D.
// Macro HSV2RGB_ROUND_EN: round half up ((num + D/2)/D) instead of floor.
module hsv2rgb_scale #(
    parameter int D   = 255,
    parameter int X_W = 8
) (
    input  logic           pclk,
    input  logic           rst,
    input  logic           ce,
    input  logic [7:0]     v,
    input  logic [X_W-1:0] x,
    output logic [7:0]     res
);
    // 8b * 14b numerator plus rounding offset stays below 2^22; one spare bit
    localparam int NUM_W = 23;

    logic [NUM_W-1:0] num;
    logic [7:0]       res_d, res_q;

    // Numerator and constant division; result never exceeds v, so 8 bits suffice
    always_comb begin
        num = NUM_W'(v) * (NUM_W'(D) - NUM_W'(x));
`ifdef HSV2RGB_ROUND_EN
        num = num + NUM_W'(D / 2);
`else
        num = num + NUM_W'(0);
`endif
        res_d = ce ? 8'(num / NUM_W'(D)) : res_q;
    end

    // Result register, held while ce is low
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) res_q <= '0;
        else     res_q <= res_d;
    end

    assign res = res_q;

endmodule

// File: rtl/hsv2rgb_top.sv
// Four-stage pipelined HSV24 -> RGB24 converter with sideband delay and a
// saturating counter of out-of-range hues.
// Macro HSV2RGB_ROUND_EN (in hsv2rgb_scale): round p/q/t half up instead of floor.
module hsv2rgb_top
    import hsv2rgb_pkg::*;
#(
    parameter int SYNC_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             ce,
    hsv2rgb_if.slave         bus,
    output logic [CNT_W-1:0] hue_err_cnt
);

    // hue decode
    logic [7:0]        h_in, h_cl;
    logic              hue_bad;
    logic [8:0]        h2, h2_base;
    sector_e           sec_in;
    logic [5:0]        f_in;

    // stage 1
    logic [7:0]        v1_d, v1_q, s1_d, s1_q;
    logic [5:0]        f1_d, f1_q;
    sector_e           sec1_d, sec1_q;
    logic              vld1_d, vld1_q;
    logic [SYNC_W-1:0] sync1_d, sync1_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;

    // stage 2
    logic [7:0]        v2_d, v2_q, s2_d, s2_q;
    logic [15:0]       sf2_d, sf2_q, sfc2_d, sfc2_q;
    sector_e           sec2_d, sec2_q;
    logic              vld2_d, vld2_q;
    logic [SYNC_W-1:0] sync2_d, sync2_q;

    // stage 3 (p/q/t registered inside the scale instances)
    logic [7:0]        p3, q3, t3;
    logic [7:0]        v3_d, v3_q;
    sector_e           sec3_d, sec3_q;
    logic              vld3_d, vld3_q;
    logic [SYNC_W-1:0] sync3_d, sync3_q;

    // stage 4
    logic [23:0]       rgb4_d, rgb4_q;
    logic              vld4_d, vld4_q;
    logic [SYNC_W-1:0] sync4_d, sync4_q;

    // Clamp hue, convert to degrees, split into sector and offset within sector
    always_comb begin
        h_in    = bus.HSV24[H_OFS +: 8];
        hue_bad = (h_in > 8'(HUE_MAX));
        h_cl    = hue_bad ? 8'(HUE_MAX) : h_in;
        h2      = {h_cl, 1'b0};
        sec_in  = sector_of(h2);
        h2_base = 9'(DEG_PER_SECTOR) * 9'(sec_in);
        f_in    = 6'(h2 - h2_base);
    end

    // Next-state for all pipeline stages; everything holds while ce is low
    always_comb begin
        v1_d    = v1_q;    s1_d   = s1_q;   f1_d   = f1_q;   sec1_d = sec1_q;
        vld1_d  = vld1_q;  sync1_d = sync1_q; cnt_d = cnt_q;
        v2_d    = v2_q;    s2_d   = s2_q;   sf2_d  = sf2_q;  sfc2_d = sfc2_q;
        sec2_d  = sec2_q;  vld2_d = vld2_q; sync2_d = sync2_q;
        v3_d    = v3_q;    sec3_d = sec3_q; vld3_d = vld3_q; sync3_d = sync3_q;
        rgb4_d  = rgb4_q;  vld4_d = vld4_q; sync4_d = sync4_q;

        if (ce) begin
            v1_d    = bus.HSV24[V_OFS +: 8];
            s1_d    = bus.HSV24[S_OFS +: 8];
            f1_d    = f_in;
            sec1_d  = sec_in;
            vld1_d  = bus.in_valid;
            sync1_d = bus.in_sync;
            if (bus.in_valid && hue_bad && (cnt_q != '1))
                cnt_d = cnt_q + CNT_W'(1);

            v2_d    = v1_q;
            s2_d    = s1_q;
            sf2_d   = 16'(s1_q) * 16'(f1_q);
            sfc2_d  = 16'(s1_q) * (16'(DEG_PER_SECTOR) - 16'(f1_q));
            sec2_d  = sec1_q;
            vld2_d  = vld1_q;
            sync2_d = sync1_q;

            v3_d    = v2_q;
            sec3_d  = sec2_q;
            vld3_d  = vld2_q;
            sync3_d = sync2_q;

            case (sec3_q)
                SEC_RY: begin
                    rgb4_d[R_OFS +: 8] = v3_q; rgb4_d[G_OFS +: 8] = t3;   rgb4_d[B_OFS +: 8] = p3;
                end
                SEC_YG: begin
                    rgb4_d[R_OFS +: 8] = q3;   rgb4_d[G_OFS +: 8] = v3_q; rgb4_d[B_OFS +: 8] = p3;
                end
                SEC_GC: begin
                    rgb4_d[R_OFS +: 8] = p3;   rgb4_d[G_OFS +: 8] = v3_q; rgb4_d[B_OFS +: 8] = t3;
                end
                SEC_CB: begin
                    rgb4_d[R_OFS +: 8] = p3;   rgb4_d[G_OFS +: 8] = q3;   rgb4_d[B_OFS +: 8] = v3_q;
                end
                SEC_BM: begin
                    rgb4_d[R_OFS +: 8] = t3;   rgb4_d[G_OFS +: 8] = p3;   rgb4_d[B_OFS +: 8] = v3_q;
                end
                default: begin
                    rgb4_d[R_OFS +: 8] = v3_q; rgb4_d[G_OFS +: 8] = p3;   rgb4_d[B_OFS +: 8] = q3;
                end
            endcase
            vld4_d  = vld3_q;
            sync4_d = sync3_q;
        end
    end

    // Pipeline registers; reset discards every in-flight pixel
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            v1_q   <= '0; s1_q   <= '0; f1_q   <= '0; sec1_q <= SEC_RY;
            vld1_q <= 1'b0; sync1_q <= '0; cnt_q <= '0;
            v2_q   <= '0; s2_q   <= '0; sf2_q  <= '0; sfc2_q <= '0;
            sec2_q <= SEC_RY; vld2_q <= 1'b0; sync2_q <= '0;
            v3_q   <= '0; sec3_q <= SEC_RY; vld3_q <= 1'b0; sync3_q <= '0;
            rgb4_q <= '0; vld4_q <= 1'b0; sync4_q <= '0;
        end else begin
            v1_q   <= v1_d;   s1_q   <= s1_d;   f1_q   <= f1_d;   sec1_q <= sec1_d;
            vld1_q <= vld1_d; sync1_q <= sync1_d; cnt_q <= cnt_d;
            v2_q   <= v2_d;   s2_q   <= s2_d;   sf2_q  <= sf2_d;  sfc2_q <= sfc2_d;
            sec2_q <= sec2_d; vld2_q <= vld2_d; sync2_q <= sync2_d;
            v3_q   <= v3_d;   sec3_q <= sec3_d; vld3_q <= vld3_d; sync3_q <= sync3_d;
            rgb4_q <= rgb4_d; vld4_q <= vld4_d; sync4_q <= sync4_d;
        end
    end

    hsv2rgb_scale #(.D(S_FULL), .X_W(8)) u_scale_p (
        .pclk (pclk), .rst (rst), .ce (ce), .v (v2_q), .x (s2_q), .res (p3)
    );

    hsv2rgb_scale #(.D(QT_DEN), .X_W(16)) u_scale_q (
        .pclk (pclk), .rst (rst), .ce (ce), .v (v2_q), .x (sf2_q), .res (q3)
    );

    hsv2rgb_scale #(.D(QT_DEN), .X_W(16)) u_scale_t (
        .pclk (pclk), .rst (rst), .ce (ce), .v (v2_q), .x (sfc2_q), .res (t3)
    );

    assign bus.out_valid = vld4_q;
    assign bus.RGB24     = rgb4_q;
    assign bus.out_sync  = sync4_q;
    assign hue_err_cnt   = cnt_q;

endmodule

// File: tb/tb_hsv2rgb_top.sv
// Self-checking bench for hsv2rgb_top: directed colour points, randomized
// streams against a behavioural HSV->RGB model, ce stalls, mid-stream reset
// and counter saturation.
module tb_hsv2rgb_top;
    localparam int SYNC_W = 3;
    localparam int CNT_W  = 16;

    typedef logic [SYNC_W+24:0] obs_t;   // {valid, sync, rgb}

    logic             pclk = 1'b0;
    logic             rst  = 1'b0;
    logic             ce   = 1'b0;
    logic [CNT_W-1:0] hue_err_cnt;
    int               vectors     = 0;
    int               miscompares = 0;

    hsv2rgb_if #(.SYNC_W(SYNC_W)) bus();

    hsv2rgb_top #(.SYNC_W(SYNC_W), .CNT_W(CNT_W)) dut (
        .pclk        (pclk),
        .rst         (rst),
        .ce          (ce),
        .bus         (bus),
        .hue_err_cnt (hue_err_cnt)
    );

    always #5 pclk = ~pclk;

    // Textbook HSV->RGB on degrees with integer arithmetic
    function automatic logic [23:0] ref_rgb(input logic [23:0] hsv);
        int h, s, v, deg, sec, f, p, q, t, r, g, b;
        h = int'(hsv[23:16]);
        if (h > 179) h = 179;
        s   = int'(hsv[15:8]);
        v   = int'(hsv[7:0]);
        deg = 2 * h;
        sec = deg / 60;
        f   = deg % 60;
`ifdef HSV2RGB_ROUND_EN
        p = (v * (255 - s) + 127) / 255;
        q = (v * (15300 - s * f) + 7650) / 15300;
        t = (v * (15300 - s * (60 - f)) + 7650) / 15300;
`else
        p = (v * (255 - s)) / 255;
        q = (v * (15300 - s * f)) / 15300;
        t = (v * (15300 - s * (60 - f))) / 15300;
`endif
        case (sec)
            0: begin r = v; g = t; b = p; end
            1: begin r = q; g = v; b = p; end
            2: begin r = p; g = v; b = t; end
            3: begin r = p; g = q; b = v; end
            4: begin r = t; g = p; b = v; end
            default: begin r = v; g = p; b = q; end
        endcase
        return {r[7:0], g[7:0], b[7:0]};
    endfunction

    // Reference: 4-deep latency line of expected outputs plus expected counter
    obs_t             dl [4];
    logic [CNT_W-1:0] cnt_exp;
    obs_t             obs;
    assign obs = {bus.out_valid, bus.out_sync, bus.RGB24};

    always @(posedge pclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) dl[i] <= '0;
            cnt_exp <= '0;
        end else if (ce) begin
            dl[0] <= {bus.in_valid, bus.in_sync, ref_rgb(bus.HSV24)};
            for (int i = 1; i < 4; i++) dl[i] <= dl[i-1];
            if (bus.in_valid && (bus.HSV24[23:16] > 8'd179) && (cnt_exp != '1))
                cnt_exp <= cnt_exp + 1'b1;
        end
    end

    task automatic drive(input logic v, input logic [23:0] hsv, input logic [SYNC_W-1:0] s);
        bus.in_valid = v;
        bus.HSV24    = hsv;
        bus.in_sync  = s;
    endtask

    task automatic drive_random();
        drive(1'($urandom_range(0, 1)), 24'($urandom), SYNC_W'($urandom));
    endtask

    task automatic pulse_reset();
        @(negedge pclk);
        rst = 1'b1;
        @(negedge pclk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        ce = 1'b1;
        drive(1'b0, 24'h0, '0);
        #1 rst = 1'b1;
        #1;
        vectors++;
        if (obs !== '0 || hue_err_cnt !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got out=%h cnt=%0d, want out=0 cnt=0", obs, hue_err_cnt);
        end
        @(negedge pclk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge pclk);
            vectors++;
            if (obs !== '0 || hue_err_cnt !== '0) begin
                miscompares++;
                $display("FAIL reset_idle[%0d]: got out=%h cnt=%0d, want 0/0", c, obs, hue_err_cnt);
            end
        end
    endtask

    task automatic test_directed();
        logic [23:0] hv [6];
        logic [23:0] ev [6];
        hv = '{24'h00FFFF, 24'h3CFFFF, 24'h78FFFF, 24'h4D0080, 24'h0FFFC8, 24'hC8FFFF};
`ifdef HSV2RGB_ROUND_EN
        ev = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h808080, 24'hC86400, 24'hFF0009};
`else
        ev = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h808080, 24'hC86400, 24'hFF0008};
`endif
        for (int k = 0; k < 6; k++) begin
            @(negedge pclk);
            drive(1'b1, hv[k], 3'b101);
            for (int j = 1; j <= 5; j++) begin
                @(negedge pclk);
                if (j == 1) drive(1'b0, 24'h0, 3'b000);
                vectors++;
                if (j == 4) begin
                    if (bus.out_valid !== 1'b1 || bus.RGB24 !== ev[k] || bus.out_sync !== 3'b101) begin
                        miscompares++;
                        $display("FAIL directed[%0d] hsv=%h: got valid=%b rgb=%h sync=%b, want 1/%h/101",
                                 k, hv[k], bus.out_valid, bus.RGB24, bus.out_sync, ev[k]);
                    end
                end else if (bus.out_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL directed_latency[%0d] cycle %0d: got valid=%b, want 0", k, j, bus.out_valid);
                end
            end
        end
        vectors++;
        if (hue_err_cnt !== 16'd1) begin
            miscompares++;
            $display("FAIL directed_cnt: got %0d, want 1", hue_err_cnt);
        end
    endtask

    task automatic test_random();
        ce = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge pclk);
            vectors++;
            if (obs !== dl[3] || hue_err_cnt !== cnt_exp) begin
                miscompares++;
                $display("FAIL random[%0d]: got out=%h cnt=%0d, want out=%h cnt=%0d", c, obs, hue_err_cnt, dl[3], cnt_exp);
            end
            drive_random();
        end
    endtask

    task automatic test_ce_stall();
        obs_t frozen;
        int   nvalid = 0;
        int   sent   = 0;
        ce = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge pclk);
            drive(1'b0, 24'h0, '0);
        end
        frozen = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge pclk);
            vectors++;
            if (obs !== dl[3] || hue_err_cnt !== cnt_exp) begin
                miscompares++;
                $display("FAIL stall[%0d]: got out=%h cnt=%0d, want out=%h cnt=%0d", c, obs, hue_err_cnt, dl[3], cnt_exp);
            end
            if (!ce) begin
                vectors++;
                if (obs !== frozen) begin
                    miscompares++;
                    $display("FAIL stall_freeze[%0d]: got out=%h, want held %h", c, obs, frozen);
                end
            end
            if (ce && bus.out_valid === 1'b1) nvalid++;
            if (c == 5) begin
                frozen = obs;
                ce = 1'b0;
            end else if (c == 8) begin
                ce = 1'b1;
            end
            if (ce) begin
                if (sent < 10) begin
                    drive(1'b1, 24'($urandom), SYNC_W'($urandom));
                    sent++;
                end else begin
                    drive(1'b0, 24'($urandom), '0);
                end
            end
        end
        vectors++;
        if (nvalid != 10) begin
            miscompares++;
            $display("FAIL stall_count: got %0d valid outputs, want 10", nvalid);
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 400; c++) begin
            @(negedge pclk);
            vectors++;
            if (obs !== dl[3] || hue_err_cnt !== cnt_exp) begin
                miscompares++;
                $display("FAIL b2b[%0d]: got out=%h cnt=%0d, want out=%h cnt=%0d", c, obs, hue_err_cnt, dl[3], cnt_exp);
            end
            ce = ($urandom_range(0, 3) != 0);
            drive_random();
        end
        ce = 1'b1;
    endtask

    task automatic test_reset_midstream();
        ce = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge pclk);
            drive(1'b1, {8'($urandom_range(0, 255)), 16'($urandom)}, 3'b111);
        end
        @(negedge pclk);
        drive(1'b0, 24'h0, '0);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (obs !== '0 || hue_err_cnt !== '0) begin
            miscompares++;
            $display("FAIL midreset_now: got out=%h cnt=%0d, want 0/0", obs, hue_err_cnt);
        end
        @(negedge pclk);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge pclk);
            vectors++;
            if (bus.out_valid !== 1'b0 || obs !== dl[3]) begin
                miscompares++;
                $display("FAIL midreset_after[%0d]: got out=%h, want valid=0 out=%h", c, obs, dl[3]);
            end
        end
    endtask

    task automatic test_saturate();
        pulse_reset();
        ce = 1'b1;
        for (int i = 0; i < 65532; i++) begin
            @(negedge pclk);
            drive(1'b1, 24'hC8FFFF, '0);
        end
        // invalid pixels with bad hue must not count
        for (int i = 0; i < 2; i++) begin
            @(negedge pclk);
            drive(1'b0, 24'hC8FFFF, '0);
        end
        @(negedge pclk);
        vectors++;
        if (hue_err_cnt !== 16'd65532) begin
            miscompares++;
            $display("FAIL sat_preset: got %0d, want 65532", hue_err_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 24'hFF1020, '0);
            @(negedge pclk);
        end
        drive(1'b0, 24'h0, '0);
        @(negedge pclk);
        vectors++;
        if (hue_err_cnt !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL sat_reach: got %0d, want 65535", hue_err_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 24'hB4FFFF, '0);
            @(negedge pclk);
        end
        drive(1'b0, 24'h0, '0);
        @(negedge pclk);
        vectors++;
        if (hue_err_cnt !== 16'hFFFF || hue_err_cnt !== cnt_exp) begin
            miscompares++;
            $display("FAIL sat_hold: got %0d, want 65535 (model %0d)", hue_err_cnt, cnt_exp);
        end
    endtask

    initial begin
        drive(1'b0, 24'h0, '0);
        test_reset();
        test_directed();
        test_random();
        test_ce_stall();
        test_back_to_back();
        test_reset_midstream();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
